// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings and the
// sequencer FSM state type.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ID   = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd10;
    localparam logic [3:0] OP_DEC  = 4'd11;
    localparam logic [3:0] OP_SHL  = 4'd12;
    localparam logic [3:0] OP_SHR  = 4'd13;
    localparam logic [3:0] OP_RR   = 4'd14;
    localparam logic [3:0] OP_RL   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: two asynchronous read ports and one
// synchronous write port shared by ALU writeback and external loads.
module alu_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 4,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   rd_addr_a,
    input  logic [RA_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_en,
    input  logic [RA_W-1:0]   ext_addr,
    input  logic [DATA_W-1:0] ext_data
);

    logic [DATA_W-1:0] regs [NREGS];

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

    // Writeback and external loads live in different FSM states, so the
    // priority order only matters as a tie-break that never happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end else if (ext_en) begin
            regs[ext_addr] <= ext_data;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer in front of a combinational 16-bit ALU.
// Optional macro CARRY_CHAIN_EN lets in_cin_sel pick carry_flag as carry-in.
module alu_op_sequencer #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 4,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [RA_W-1:0]   in_rs,
    input  logic [RA_W-1:0]   in_rt,
    input  logic              in_cin,
    input  logic              in_cin_sel,
    input  logic              wr_en,
    input  logic [RA_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic              alu_cout,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_cout,
    output logic              carry_flag,
    output logic              busy
);

    import alu_pkg::*;

    seq_state_t        state_q, state_d;
    logic [RA_W-1:0]   rd_q;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              cin_sel;
    logic              accept;
    logic              ext_en;
    logic              wb_en;

`ifdef CARRY_CHAIN_EN
    assign cin_sel = in_cin_sel ? carry_flag : in_cin;
`else
    logic unused_cin_sel;
    assign unused_cin_sel = in_cin_sel;
    assign cin_sel        = in_cin;
`endif

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign accept   = in_ready && in_valid;
    assign wb_en    = (state_q == EXEC);
    assign ext_en   = wr_en && (state_q == IDLE);

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .RA_W   (RA_W)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (in_rs),
        .rd_addr_b (in_rt),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .wb_en     (wb_en),
        .wb_addr   (rd_q),
        .wb_data   (alu_c),
        .ext_en    (ext_en),
        .ext_addr  (wr_addr),
        .ext_data  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture reads the pre-write register contents when an
    // external load lands on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_op     <= '0;
            rd_q       <= '0;
            out_data   <= '0;
            out_cout   <= 1'b0;
            carry_flag <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a   <= rf_a;
                alu_b   <= rf_b;
                alu_op  <= in_op;
                alu_cin <= cin_sel;
                rd_q    <= in_rd;
            end
            if (state_q == EXEC) begin
                out_data   <= alu_c;
                out_cout   <= alu_cout;
                carry_flag <= alu_cout;
                out_valid  <= 1'b1;
            end else if (state_q == DONE) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
